// File: rtl/mac_pkg.sv
// mac_pkg: shared types and width/limit helpers for the MAC accumulator.
//   state_e    : accumulator FSM state
//   acc_width  : accumulator width from multiplier operand width and guard bits
//   sat_max    : most positive signed value of an aw-bit word (zero-extended to MAX_AW)
//   sat_min    : most negative signed value of an aw-bit word (sign-extended to MAX_AW)
package mac_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  localparam int CNT_W  = 16;
  localparam int MAX_AW = 256;

  function automatic int acc_width(input int width, input int guard);
    return 2 * width + guard;
  endfunction

  // Callers keep only the low aw bits of the returned word.
  function automatic logic [MAX_AW-1:0] sat_max(input int aw);
    logic [MAX_AW-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_AW; i++) begin
      if (i < aw - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [MAX_AW-1:0] sat_min(input int aw);
    logic [MAX_AW-1:0] v;
    v = '1;
    for (int i = 0; i < MAX_AW; i++) begin
      if (i < aw - 1) v[i] = 1'b0;
    end
    return v;
  endfunction

endpackage

// File: rtl/mac_accumulator_sat_adder.sv
// sat_adder: combinational signed AW-bit adder with saturation.
//   i_a, i_b : signed addends
//   o_sum    : a+b clamped to the AW-bit signed range
//   o_ovf    : high when the clamp was applied
module sat_adder
  import mac_pkg::*;
#(
  parameter int AW = 72
) (
  input  logic signed [AW-1:0] i_a,
  input  logic signed [AW-1:0] i_b,
  output logic signed [AW-1:0] o_sum,
  output logic                 o_ovf
);

  localparam logic [MAX_AW-1:0] MAX_FULL = sat_max(AW);
  localparam logic [MAX_AW-1:0] MIN_FULL = sat_min(AW);
  localparam logic [AW-1:0]     MAX_V    = MAX_FULL[AW-1:0];
  localparam logic [AW-1:0]     MIN_V    = MIN_FULL[AW-1:0];

  logic [AW:0] w_wide;
  logic        w_pos_ovf;
  logic        w_neg_ovf;

  // One extra bit holds the true sum; the top two bits disagree only on overflow,
  // and the extra bit gives the direction.
  assign w_wide    = {i_a[AW-1], i_a} + {i_b[AW-1], i_b};
  assign w_pos_ovf = !w_wide[AW] &&  w_wide[AW-1];
  assign w_neg_ovf =  w_wide[AW] && !w_wide[AW-1];

  always_comb begin
    o_sum = w_wide[AW-1:0];
    if (w_pos_ovf)      o_sum = MAX_V;
    else if (w_neg_ovf) o_sum = MIN_V;
  end

  assign o_ovf = w_pos_ovf | w_neg_ovf;

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: sums a vector of up to LEN signed products into a guarded,
// saturating accumulator and hands one dot-product result per vector to a
// holding register.
//   clk, rst_n            : clock, synchronous active-low reset
//   clr                   : abort the vector in progress (held result kept)
//   in_valid/in_ready     : product handshake; in_last ends the vector early
//   in_product            : signed 2*WIDTH product
//   out_valid/out_ready   : result handshake
//   out_sum/out_count     : saturated sum and number of products in the vector
//   out_ovf               : saturation happened somewhere in the vector
//
// state | meaning
// IDLE  | no partial vector; acc and cnt are zero
// ACCUM | at least one product of the current vector accepted
module mac_accumulator
  import mac_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int LEN   = 16,
  parameter  int GUARD = 8,
  localparam int PW    = 2 * WIDTH,
  localparam int AW    = acc_width(WIDTH, GUARD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [PW-1:0] in_product,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_ovf
);

  state_e              r_state;
  state_e              w_state_nxt;

  logic signed [AW-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ovf_acc;

  logic                 r_out_valid;
  logic signed [AW-1:0] r_out_sum;
  logic [CNT_W-1:0]     r_out_count;
  logic                 r_out_ovf;

  logic                 w_in_ready;
  logic                 w_fire;
  logic                 w_term;
  logic [CNT_W:0]       w_cnt_inc;
  logic signed [AW-1:0] w_prod_ext;
  logic signed [AW-1:0] w_acc_base;
  logic signed [AW-1:0] w_sum;
  logic                 w_beat_ovf;
  logic                 w_acc_clear;
  logic                 w_acc_load;

  // A held result only blocks input when the consumer is not taking it now,
  // so back-to-back vectors keep full throughput.
  assign w_in_ready = !clr && (!r_out_valid || out_ready);
  assign w_fire     = in_valid && w_in_ready;
  assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_term     = w_fire && (in_last || (w_cnt_inc == (CNT_W+1)'(LEN)));
  assign w_prod_ext = AW'(in_product);

  sat_adder #(.AW(AW)) u_sat_adder (
    .i_a   (w_acc_base),
    .i_b   (w_prod_ext),
    .o_sum (w_sum),
    .o_ovf (w_beat_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clr || w_term) w_state_nxt = IDLE;
    else if (w_fire)   w_state_nxt = ACCUM;
  end

  always_comb begin
    w_acc_base  = (r_state == ACCUM) ? r_acc : '0;
    w_acc_clear = clr || w_term;
    w_acc_load  = w_fire && !w_term;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
    end else if (w_acc_clear) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf_acc <= 1'b0;
    end else if (w_acc_load) begin
      r_acc     <= w_sum;
      r_cnt     <= w_cnt_inc[CNT_W-1:0];
      r_ovf_acc <= r_ovf_acc | w_beat_ovf;
    end
  end

  // A terminating beat can only fire when the held slot is empty or being
  // popped, so loading here never overwrites an undelivered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_term) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum;
      r_out_count <= w_cnt_inc[CNT_W-1:0];
      r_out_ovf   <= r_ovf_acc | w_beat_ovf;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign out_ovf   = r_out_ovf;

endmodule
